// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the CPU/debug RAM arbiter.
package mem_arb_pkg;
    localparam int ADDR_W_DEF   = 8;
    localparam int DATA_W_DEF   = 16;
    localparam int LOCK_MAX_DEF = 255;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CPU  = 2'd1,
        ARB_DBG  = 2'd2,
        ARB_LOCK = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the RAM.
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              cpu_req, cpu_write, cpu_gnt, cpu_rvalid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              dbg_req, dbg_write, dbg_lock, dbg_gnt, dbg_rvalid;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write;
    logic [DATA_W-1:0] mem_din, mem_dout;
    logic              lock_timeout;

    modport slave (
        input  cpu_req, cpu_write, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_write, dbg_addr, dbg_wdata, dbg_lock,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_addr, mem_write, mem_din,
        input  mem_dout,
        output lock_timeout
    );

    modport master (
        output cpu_req, cpu_write, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_write, dbg_addr, dbg_wdata, dbg_lock,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_addr, mem_write, mem_din,
        output mem_dout,
        input  lock_timeout
    );
endinterface

// File: rtl/mem_arbiter_lock_watchdog.sv
// Debug-lock hold counter with forced-release compare and sticky timeout flag.
module lock_watchdog #(
    parameter int LOCK_MAX = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic lock_active,
    input  logic lock_req,
    output logic expire,
    output logic lock_timeout
);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    // Fires in the LOCK_MAX-th held cycle so the lock lasts exactly LOCK_MAX cycles.
    assign expire       = lock_active && lock_req && (r_cnt == CNT_W'(LOCK_MAX - 1));
    assign lock_timeout = r_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (!lock_active || !lock_req || expire) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (expire) begin
                r_timeout <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// CPU/debug arbiter for a single-port sync-read RAM with debug lock.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; default is CPU-first.
//
// state    | meaning
// ARB_IDLE | nobody won the previous cycle
// ARB_CPU  | CPU won the previous cycle
// ARB_DBG  | debug won the previous cycle (no lock taken)
// ARB_LOCK | debug owns the RAM exclusively, CPU blocked
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input logic      clk,
    input logic      reset,
    mem_arb_if.slave bus
);
    arb_state_t        r_state, w_next_state;
    logic              r_tag_valid;
    owner_t            r_tag_owner;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_lock_blocked;
    logic              w_cpu_gnt, w_dbg_gnt, w_lock_active, w_expire;
    logic              w_cpu_rvalid, w_dbg_rvalid;
    logic [ADDR_W-1:0] w_mem_addr;
    owner_t            w_tie_winner;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t r_last_owner;

    assign w_tie_winner = (r_last_owner == OWN_DBG) ? OWN_CPU : OWN_DBG;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_owner <= OWN_DBG;
        end else if (w_cpu_gnt) begin
            r_last_owner <= OWN_CPU;
        end else if (w_dbg_gnt) begin
            r_last_owner <= OWN_DBG;
        end
    end
`else
    assign w_tie_winner = OWN_CPU;
`endif

    assign w_lock_active = (r_state == ARB_LOCK);

    lock_watchdog #(.LOCK_MAX(LOCK_MAX)) u_lock_watchdog (
        .clk          (clk),
        .reset        (reset),
        .lock_active  (w_lock_active),
        .lock_req     (bus.dbg_lock),
        .expire       (w_expire),
        .lock_timeout (bus.lock_timeout)
    );

    always_comb begin
        w_cpu_gnt    = 1'b0;
        w_dbg_gnt    = 1'b0;
        w_next_state = ARB_IDLE;
        if (reset) begin
            w_next_state = ARB_IDLE;
        end else if (w_lock_active) begin
            w_dbg_gnt    = bus.dbg_req;
            w_next_state = (!bus.dbg_lock || w_expire) ? ARB_IDLE : ARB_LOCK;
        end else begin
            if (bus.cpu_req && bus.dbg_req) begin
                w_cpu_gnt = (w_tie_winner == OWN_CPU);
                w_dbg_gnt = !w_cpu_gnt;
            end else begin
                w_cpu_gnt = bus.cpu_req;
                w_dbg_gnt = bus.dbg_req;
            end
            // A forced release keeps the lock refused until dbg_lock drops once.
            if (w_dbg_gnt && bus.dbg_lock && !r_lock_blocked) begin
                w_next_state = ARB_LOCK;
            end else if (w_cpu_gnt) begin
                w_next_state = ARB_CPU;
            end else if (w_dbg_gnt) begin
                w_next_state = ARB_DBG;
            end
        end
    end

    assign w_mem_addr    = w_dbg_gnt ? bus.dbg_addr : (w_cpu_gnt ? bus.cpu_addr : r_mem_addr);
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_din   = w_dbg_gnt ? bus.dbg_wdata : bus.cpu_wdata;
    assign bus.mem_write = (w_cpu_gnt & bus.cpu_write) | (w_dbg_gnt & bus.dbg_write);
    assign bus.cpu_gnt   = w_cpu_gnt;
    assign bus.dbg_gnt   = w_dbg_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ARB_IDLE;
            r_tag_valid    <= 1'b0;
            r_tag_owner    <= OWN_CPU;
            r_mem_addr     <= '0;
            r_lock_blocked <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_tag_valid <= (w_cpu_gnt & ~bus.cpu_write) | (w_dbg_gnt & ~bus.dbg_write);
            r_tag_owner <= w_dbg_gnt ? OWN_DBG : OWN_CPU;
            if (w_cpu_gnt || w_dbg_gnt) begin
                r_mem_addr <= w_mem_addr;
            end
            if (!bus.dbg_lock) begin
                r_lock_blocked <= 1'b0;
            end else if (w_expire) begin
                r_lock_blocked <= 1'b1;
            end
        end
    end

    assign w_cpu_rvalid   = r_tag_valid && (r_tag_owner == OWN_CPU);
    assign w_dbg_rvalid   = r_tag_valid && (r_tag_owner == OWN_DBG);
    assign bus.cpu_rvalid = w_cpu_rvalid;
    assign bus.dbg_rvalid = w_dbg_rvalid;
    assign bus.cpu_rdata  = w_cpu_rvalid ? bus.mem_dout : '0;
    assign bus.dbg_rdata  = w_dbg_rvalid ? bus.mem_dout : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    logic m_last_dbg;
    logic [15:0] ram [256] = '{default: 16'h0000};
    logic [15:0] ref_mem [256] = '{default: 16'h0000};

    mem_arb_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    mem_arbiter #(.ADDR_W(8), .DATA_W(16), .LOCK_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_write) ram[bus.mem_addr] <= bus.mem_din;
        bus.mem_dout <= ram[bus.mem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [15:0] cd,
                         input logic dr, input logic dw, input logic [7:0] da, input logic [15:0] dd,
                         input logic dl);
        bus.cpu_req = cr; bus.cpu_write = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
        bus.dbg_req = dr; bus.dbg_write = dw; bus.dbg_addr = da; bus.dbg_wdata = dd;
        bus.dbg_lock = dl;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive(0, 0, 8'd0, 16'd0, 0, 0, 8'd0, 16'd0, 0);
        step();
        step();
        reset = 1'b0;
        m_last_dbg = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1, 0, 8'd1, 16'd0, 1, 0, 8'd2, 16'd0, 0);
        @(negedge clk);
        n_checks++; if (bus.cpu_gnt !== 1'b0) begin n_errors++; $display("FAIL rst_cpu_gnt: got %b exp 0", bus.cpu_gnt); end
        n_checks++; if (bus.dbg_gnt !== 1'b0) begin n_errors++; $display("FAIL rst_dbg_gnt: got %b exp 0", bus.dbg_gnt); end
        step();
        step();
        reset = 1'b0;
        m_last_dbg = 1'b1;
        drive(0, 0, 8'd0, 16'd0, 0, 0, 8'd0, 16'd0, 0);
        @(negedge clk);
        n_checks++; if (bus.cpu_rvalid !== 1'b0) begin n_errors++; $display("FAIL rst_cpu_rvalid: got %b exp 0", bus.cpu_rvalid); end
        n_checks++; if (bus.dbg_rvalid !== 1'b0) begin n_errors++; $display("FAIL rst_dbg_rvalid: got %b exp 0", bus.dbg_rvalid); end
        n_checks++; if (bus.cpu_rdata !== 16'h0) begin n_errors++; $display("FAIL rst_cpu_rdata: got %h exp 0", bus.cpu_rdata); end
        n_checks++; if (bus.dbg_rdata !== 16'h0) begin n_errors++; $display("FAIL rst_dbg_rdata: got %h exp 0", bus.dbg_rdata); end
        n_checks++; if (bus.lock_timeout !== 1'b0) begin n_errors++; $display("FAIL rst_timeout: got %b exp 0", bus.lock_timeout); end
        n_checks++; if (dut.r_state !== ARB_IDLE) begin n_errors++; $display("FAIL rst_state: got %0d exp %0d", dut.r_state, ARB_IDLE); end
        step();
    endtask

    task automatic test_cpu_write_read();
        apply_reset();
        drive(1, 1, 8'd25, 16'hFFE9, 0, 0, 8'd0, 16'd0, 0);
        @(negedge clk);
        n_checks++; if (bus.cpu_gnt !== 1'b1) begin n_errors++; $display("FAIL wr_gnt: got %b exp 1", bus.cpu_gnt); end
        n_checks++; if (bus.mem_write !== 1'b1 || bus.mem_addr !== 8'd25) begin n_errors++; $display("FAIL wr_mem: got we=%b addr=%0d exp we=1 addr=25", bus.mem_write, bus.mem_addr); end
        step();
        ref_mem[25] = 16'hFFE9;
        drive(1, 0, 8'd25, 16'h0, 0, 0, 8'd0, 16'd0, 0);
        @(negedge clk);
        n_checks++; if (bus.cpu_gnt !== 1'b1) begin n_errors++; $display("FAIL rd_gnt: got %b exp 1", bus.cpu_gnt); end
        n_checks++; if (bus.cpu_rvalid !== 1'b0) begin n_errors++; $display("FAIL wr_no_rvalid: got %b exp 0", bus.cpu_rvalid); end
        step();
        drive(0, 0, 8'd0, 16'd0, 0, 0, 8'd0, 16'd0, 0);
        @(negedge clk);
        n_checks++; if (bus.cpu_rvalid !== 1'b1) begin n_errors++; $display("FAIL rd_rvalid: got %b exp 1", bus.cpu_rvalid); end
        n_checks++; if (bus.cpu_rdata !== 16'hFFE9) begin n_errors++; $display("FAIL rd_rdata: got %h exp ffe9", bus.cpu_rdata); end
        n_checks++; if (bus.dbg_rvalid !== 1'b0) begin n_errors++; $display("FAIL rd_dbg_rvalid: got %b exp 0", bus.dbg_rvalid); end
        n_checks++; if (bus.mem_write !== 1'b0 || bus.mem_addr !== 8'd25) begin n_errors++; $display("FAIL idle_hold: got we=%b addr=%0d exp we=0 addr=25", bus.mem_write, bus.mem_addr); end
        step();
    endtask

    task automatic test_tie();
        logic exp_c, prev_c;
        apply_reset();
        prev_c = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1, 0, 8'd25, 16'd0, 1, 0, 8'd40, 16'd0, 0);
            else       drive(0, 0, 8'd0, 16'd0, 0, 0, 8'd0, 16'd0, 0);
            exp_c = RR ? m_last_dbg : 1'b1;
            @(negedge clk);
            if (i < 4) begin
                n_checks++; if (bus.cpu_gnt !== exp_c || bus.dbg_gnt !== !exp_c) begin n_errors++; $display("FAIL tie_gnt[%0d]: got cpu=%b dbg=%b exp cpu=%b dbg=%b", i, bus.cpu_gnt, bus.dbg_gnt, exp_c, !exp_c); end
            end
            if (i > 0) begin
                n_checks++; if (bus.cpu_rvalid !== prev_c || bus.dbg_rvalid !== !prev_c) begin n_errors++; $display("FAIL tie_rvalid[%0d]: got cpu=%b dbg=%b exp cpu=%b dbg=%b", i, bus.cpu_rvalid, bus.dbg_rvalid, prev_c, !prev_c); end
            end
            m_last_dbg = !exp_c;
            prev_c = exp_c;
            step();
        end
    endtask

    task automatic test_lock_exit();
        apply_reset();
        drive(0, 0, 8'd0, 16'd0, 1, 0, 8'd7, 16'd0, 1);
        @(negedge clk);
        n_checks++; if (bus.dbg_gnt !== 1'b1) begin n_errors++; $display("FAIL lk_entry_gnt: got %b exp 1", bus.dbg_gnt); end
        step();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 8'd9, 16'd0, 0, 0, 8'd0, 16'd0, (k < 2));
            @(negedge clk);
            n_checks++; if (bus.cpu_gnt !== 1'b0) begin n_errors++; $display("FAIL lk_block[%0d]: got %b exp 0", k, bus.cpu_gnt); end
            step();
        end
        drive(1, 0, 8'd9, 16'd0, 0, 0, 8'd0, 16'd0, 0);
        @(negedge clk);
        n_checks++; if (bus.cpu_gnt !== 1'b1) begin n_errors++; $display("FAIL lk_exit_gnt: got %b exp 1", bus.cpu_gnt); end
        n_checks++; if (bus.lock_timeout !== 1'b0) begin n_errors++; $display("FAIL lk_no_timeout: got %b exp 0", bus.lock_timeout); end
        step();
    endtask

    task automatic test_read_then_write();
        apply_reset();
        drive(0, 0, 8'd0, 16'd0, 1, 1, 8'd3, 16'h1234, 0);
        @(negedge clk);
        n_checks++; if (bus.dbg_gnt !== 1'b1 || bus.mem_write !== 1'b1) begin n_errors++; $display("FAIL rw_dbg_wr: got gnt=%b we=%b exp 1/1", bus.dbg_gnt, bus.mem_write); end
        step();
        ref_mem[3] = 16'h1234;
        drive(0, 0, 8'd0, 16'd0, 1, 0, 8'd3, 16'h0, 0);
        @(negedge clk);
        n_checks++; if (bus.dbg_gnt !== 1'b1) begin n_errors++; $display("FAIL rw_dbg_rd_gnt: got %b exp 1", bus.dbg_gnt); end
        step();
        drive(1, 1, 8'd3, 16'hBEEF, 0, 0, 8'd0, 16'd0, 0);
        @(negedge clk);
        n_checks++; if (bus.cpu_gnt !== 1'b1 || bus.mem_write !== 1'b1) begin n_errors++; $display("FAIL rw_cpu_wr: got gnt=%b we=%b exp 1/1", bus.cpu_gnt, bus.mem_write); end
        n_checks++; if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== 16'h1234) begin n_errors++; $display("FAIL rw_dbg_ret: got v=%b d=%h exp 1/1234", bus.dbg_rvalid, bus.dbg_rdata); end
        n_checks++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 16'h0) begin n_errors++; $display("FAIL rw_cpu_quiet: got v=%b d=%h exp 0/0", bus.cpu_rvalid, bus.cpu_rdata); end
        step();
        ref_mem[3] = 16'hBEEF;
        drive(1, 0, 8'd3, 16'h0, 0, 0, 8'd0, 16'd0, 0);
        step();
        drive(0, 0, 8'd0, 16'd0, 0, 0, 8'd0, 16'd0, 0);
        @(negedge clk);
        n_checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 16'hBEEF) begin n_errors++; $display("FAIL rw_readback: got v=%b d=%h exp 1/beef", bus.cpu_rvalid, bus.cpu_rdata); end
        step();
    endtask

    task automatic test_lock_timeout();
        apply_reset();
        drive(0, 0, 8'd0, 16'd0, 1, 0, 8'd7, 16'd0, 1);
        @(negedge clk);
        n_checks++; if (bus.dbg_gnt !== 1'b1) begin n_errors++; $display("FAIL to_entry: got %b exp 1", bus.dbg_gnt); end
        step();
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 8'd9, 16'd0, 0, 0, 8'd0, 16'd0, 1);
            @(negedge clk);
            n_checks++; if (bus.cpu_gnt !== 1'b0 || bus.lock_timeout !== 1'b0) begin n_errors++; $display("FAIL to_held[%0d]: got gnt=%b to=%b exp 0/0", k, bus.cpu_gnt, bus.lock_timeout); end
            step();
        end
        drive(1, 0, 8'd9, 16'd0, 0, 0, 8'd0, 16'd0, 1);
        @(negedge clk);
        n_checks++; if (bus.cpu_gnt !== 1'b1 || bus.lock_timeout !== 1'b1) begin n_errors++; $display("FAIL to_release: got gnt=%b to=%b exp 1/1", bus.cpu_gnt, bus.lock_timeout); end
        step();
        drive(0, 0, 8'd0, 16'd0, 1, 0, 8'd7, 16'd0, 1);
        @(negedge clk);
        n_checks++; if (bus.dbg_gnt !== 1'b1) begin n_errors++; $display("FAIL to_dbg_plain: got %b exp 1", bus.dbg_gnt); end
        step();
        drive(1, 0, 8'd9, 16'd0, 0, 0, 8'd0, 16'd0, 1);
        @(negedge clk);
        n_checks++; if (bus.cpu_gnt !== 1'b1) begin n_errors++; $display("FAIL to_no_relock: got %b exp 1", bus.cpu_gnt); end
        step();
        drive(0, 0, 8'd0, 16'd0, 0, 0, 8'd0, 16'd0, 0);
        step();
        drive(0, 0, 8'd0, 16'd0, 1, 0, 8'd7, 16'd0, 1);
        step();
        drive(1, 0, 8'd9, 16'd0, 1, 0, 8'd3, 16'd0, 0);
        @(negedge clk);
        n_checks++; if (bus.cpu_gnt !== 1'b0 || bus.dbg_gnt !== 1'b1) begin n_errors++; $display("FAIL to_relock: got cpu=%b dbg=%b exp 0/1", bus.cpu_gnt, bus.dbg_gnt); end
        step();
        reset = 1'b1;
        drive(1, 0, 8'd9, 16'd0, 1, 0, 8'd3, 16'd0, 0);
        @(negedge clk);
        n_checks++; if (bus.cpu_gnt !== 1'b0 || bus.dbg_gnt !== 1'b0) begin n_errors++; $display("FAIL mid_rst_gnt: got cpu=%b dbg=%b exp 0/0", bus.cpu_gnt, bus.dbg_gnt); end
        step();
        reset = 1'b0;
        m_last_dbg = 1'b1;
        drive(0, 0, 8'd0, 16'd0, 0, 0, 8'd0, 16'd0, 0);
        @(negedge clk);
        n_checks++; if (bus.cpu_rvalid !== 1'b0 || bus.dbg_rvalid !== 1'b0) begin n_errors++; $display("FAIL mid_rst_rvalid: got cpu=%b dbg=%b exp 0/0", bus.cpu_rvalid, bus.dbg_rvalid); end
        n_checks++; if (dut.r_state !== ARB_IDLE) begin n_errors++; $display("FAIL mid_rst_state: got %0d exp %0d", dut.r_state, ARB_IDLE); end
        n_checks++; if (bus.lock_timeout !== 1'b0) begin n_errors++; $display("FAIL mid_rst_timeout: got %b exp 0", bus.lock_timeout); end
        step();
    endtask

    task automatic test_random(input int n);
        logic c_pend, d_pend, c_w, d_w, exp_c, exp_d, pv, po;
        logic [7:0]  c_a, d_a;
        logic [15:0] c_d, d_d, pd, exp_cd, exp_dd;
        apply_reset();
        c_pend = 0; d_pend = 0; pv = 0; po = 0; pd = '0;
        c_w = 0; d_w = 0; c_a = '0; d_a = '0; c_d = '0; d_d = '0;
        for (int i = 0; i < n; i++) begin
            if (!c_pend) begin
                c_pend = ($urandom_range(0, 3) != 0);
                c_w = 1'($urandom_range(0, 1)); c_a = 8'($urandom_range(0, 15)); c_d = 16'($urandom);
            end
            if (!d_pend) begin
                d_pend = ($urandom_range(0, 3) != 0);
                d_w = 1'($urandom_range(0, 1)); d_a = 8'($urandom_range(0, 15)); d_d = 16'($urandom);
            end
            drive(c_pend, c_w, c_a, c_d, d_pend, d_w, d_a, d_d, 0);
            exp_c  = (c_pend && d_pend) ? (RR ? m_last_dbg : 1'b1) : c_pend;
            exp_d  = d_pend && !exp_c;
            exp_cd = (pv && !po) ? pd : 16'h0;
            exp_dd = (pv && po) ? pd : 16'h0;
            @(negedge clk);
            n_checks++; if (bus.cpu_gnt !== exp_c || bus.dbg_gnt !== exp_d) begin n_errors++; $display("FAIL rnd_gnt[%0d]: got cpu=%b dbg=%b exp cpu=%b dbg=%b", i, bus.cpu_gnt, bus.dbg_gnt, exp_c, exp_d); end
            n_checks++; if (bus.cpu_rvalid !== (pv && !po) || bus.dbg_rvalid !== (pv && po)) begin n_errors++; $display("FAIL rnd_rvalid[%0d]: got cpu=%b dbg=%b exp cpu=%b dbg=%b", i, bus.cpu_rvalid, bus.dbg_rvalid, pv && !po, pv && po); end
            n_checks++; if (bus.cpu_rdata !== exp_cd || bus.dbg_rdata !== exp_dd) begin n_errors++; $display("FAIL rnd_rdata[%0d]: got cpu=%h dbg=%h exp cpu=%h dbg=%h", i, bus.cpu_rdata, bus.dbg_rdata, exp_cd, exp_dd); end
            n_checks++; if (bus.mem_write !== ((exp_c & c_w) | (exp_d & d_w))) begin n_errors++; $display("FAIL rnd_we[%0d]: got %b exp %b", i, bus.mem_write, (exp_c & c_w) | (exp_d & d_w)); end
            if (exp_c || exp_d) begin
                n_checks++; if (bus.mem_addr !== (exp_c ? c_a : d_a)) begin n_errors++; $display("FAIL rnd_addr[%0d]: got %0d exp %0d", i, bus.mem_addr, exp_c ? c_a : d_a); end
            end
            pv = 1'b0;
            if (exp_c) begin
                if (c_w) ref_mem[c_a] = c_d;
                else begin pv = 1'b1; po = 1'b0; pd = ref_mem[c_a]; end
                m_last_dbg = 1'b0;
                c_pend = 1'b0;
            end
            if (exp_d) begin
                if (d_w) ref_mem[d_a] = d_d;
                else begin pv = 1'b1; po = 1'b1; pd = ref_mem[d_a]; end
                m_last_dbg = 1'b1;
                d_pend = 1'b0;
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        m_last_dbg = 1'b1;
        drive(0, 0, 8'd0, 16'd0, 0, 0, 8'd0, 16'd0, 0);
        test_reset();
        test_cpu_write_read();
        test_tie();
        test_lock_exit();
        test_read_then_write();
        test_lock_timeout();
        test_random(300);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port, synchronous-read 256x16 RAM between the CPU and a debug/loader master. It sits between the CPU's memory interface and the RAM instance in the top level. It grants one access per cycle and returns read data one cycle later, tagged to the original requester. It also supports an exclusive debug lock with a watchdog, so a debug master can freeze the CPU's memory traffic while it inspects or patches memory.

## Interface
Parameters:
- ADDR_W, 8, RAM address width
- DATA_W, 16, RAM word width
- LOCK_MAX, 255, maximum cycles a debug lock may be held before forced release

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request
- cpu_write  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access accepted this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- dbg_req, dbg_write, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug request, same meaning as the CPU signals
- dbg_lock  in  1  debug requests exclusive ownership
- dbg_gnt, dbg_rvalid, dbg_rdata  out  1/1/DATA_W  debug handshake outputs
- mem_addr  out  ADDR_W  RAM address
- mem_write  out  1  RAM write enable
- mem_din  out  DATA_W  RAM write data
- mem_dout  in  DATA_W  RAM read data, valid one cycle after the address
- lock_timeout  out  1  sticky flag; watchdog forced a lock release

## Operation
- FSM states: ARB_IDLE, ARB_CPU, ARB_DBG, ARB_LOCK.
  - The state records the winner of the current cycle.
  - ARB_LOCK means the debug master owns the RAM exclusively.
- Arbitration in ARB_IDLE, ARB_CPU and ARB_DBG:
  - Exactly one requester wins per cycle.
  - *_gnt is combinational and asserts in the same cycle as the winning *_req.
  - mem_addr, mem_write and mem_din are combinationally muxed from the winner.
  - mem_write = winner's *_write & *_gnt.
  - With no winner, mem_write = 0 and mem_addr holds its last value.
- Handshake:
  - A requester holds req, write, addr and wdata stable until it sees gnt high at a clock edge.
  - The transfer occurs on that edge.
  - Deasserting req before gnt is legal and cancels the request.
- Read return:
  - A registered tag records {valid, owner} for a granted read.
  - On the next cycle, owner_rvalid = 1 and owner_rdata = mem_dout; the other port's rdata = 0.
  - Writes produce no rvalid.
- Lock entry: when dbg is granted with dbg_lock = 1, the next state is ARB_LOCK.
- ARB_LOCK behaviour:
  - cpu_gnt = 0.
  - dbg_req is granted every cycle it is asserted.
  - A lock counter increments every cycle.
- Lock exit:
  - If dbg_lock = 0, the next state is ARB_IDLE and the counter clears.
  - If the counter reaches LOCK_MAX, the next state is ARB_IDLE, lock_timeout sets, and the counter clears.
  - After a forced exit, a fresh lock is accepted only after dbg_lock has been seen low for at least one cycle.
- lock_timeout clears only on reset.
- Widths: the lock counter is $clog2(LOCK_MAX+1) bits and must not wrap.

## Timing
- Reset values:
  - state = ARB_IDLE, tag = invalid, both *_rvalid = 0, both *_rdata = 0.
  - lock_timeout = 0, lock counter = 0.
  - Priority pointer = "debug last", so the CPU wins the first tie.
- Grant latency is 0 cycles; read latency is 1 cycle after grant.
- Throughput: one access per cycle with no bubbles. Back-to-back grants to alternating owners return rvalid on alternating ports in consecutive cycles.
- Simultaneous requests resolve as described under Configuration.
- Reset asserted mid-operation:
  - Takes effect at the next edge and drops any pending rvalid.
  - Grants are forced to 0 in the cycle reset is high.

## Configuration
- ARB_ROUND_ROBIN_EN
  - Defined: on a tie, the requester that did not win the most recent grant wins. The pointer updates on every grant.
  - Undefined: fixed priority, the CPU always wins ties, and the pointer logic is compiled out.
- ARB_LOCK behaviour is identical in both modes.

## Structure
- A shared package `mem_arb_pkg` holds:
  - The state enum ARB_IDLE/ARB_CPU/ARB_DBG/ARB_LOCK.
  - An owner enum OWN_CPU/OWN_DBG.
  - The default widths.
- One sub-module, `lock_watchdog`, contains the counter, the LOCK_MAX compare and the sticky lock_timeout flag. Its inputs are lock_active and lock_req; its outputs are expire and lock_timeout.
- The top module contains the FSM, the mux and the return tag.

## Test plan
- Reset, then CPU write of addr 8'd25 with data 16'hFFE9, then CPU read of addr 25:
  - cpu_gnt is high in each request cycle.
  - The cycle after the read grant, cpu_rvalid = 1 and cpu_rdata = 16'hFFE9.
  - dbg_rvalid stays 0 throughout.
- cpu_req and dbg_req held high together for 4 cycles:
  - With ARB_ROUND_ROBIN_EN, grants go CPU, DBG, CPU, DBG.
  - Without it, all 4 grants go to the CPU.
- dbg_req with dbg_lock = 1 granted at cycle N:
  - cpu_req held high gets cpu_gnt = 0 from N+1 until dbg_lock falls.
  - The CPU is granted in the first cycle after the exit.
- Lock held with LOCK_MAX = 4:
  - Forced release occurs 4 cycles after lock entry and lock_timeout = 1.
  - No re-lock occurs until dbg_lock has toggled low.
- Debug read of addr 3 granted in cycle N, CPU write granted in cycle N+1:
  - In N+1, dbg_rvalid = 1 and cpu_rvalid = 0.
  - The RAM write occurs at the end of N+1.
- Reset asserted during a pending read:
  - The next cycle has both rvalid = 0 and state = ARB_IDLE.
  - lock_timeout is cleared.
